// File: rtl/countdown_scheduler.sv
// Batched start/ready sequencer for the countdown counter: queues run requests and replays the counter.
// Optional COUNTDOWN_SCHED_STATS_EN adds the stat_runs completed-run counter output.
module countdown_scheduler #(
  parameter int DEPTH       = 4,
  parameter int RUN_W       = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [RUN_W-1:0] req_runs,
  output logic             start,
  input  logic             ready,
  output logic             busy,
  output logic [RUN_W-1:0] runs_left,
  output logic             batch_done,
`ifdef COUNTDOWN_SCHED_STATS_EN
  output logic [31:0]      stat_runs,
`endif
  output logic             timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_FIRE      = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_ERROR     = 3'd5;

  logic [RUN_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [2:0]       state;
  logic [TW-1:0]    timer;
  logic [RUN_W-1:0] head;
  logic             push;
  logic             pop;

  assign req_ready = (count != FULL_CNT) && (state != S_ERROR);
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_LOAD);
  assign busy      = (state != S_IDLE) || (count != {CW{1'b0}});
  assign head      = mem[rd_ptr];

  // Request storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= req_runs;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally with a power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: start is raised one cycle ahead so it is high while the FSM sits in FIRE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      start       <= 1'b0;
      batch_done  <= 1'b0;
      runs_left   <= {RUN_W{1'b0}};
      timeout_err <= 1'b0;
      timer       <= {TW{1'b0}};
    end else begin
      start      <= 1'b0;
      batch_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != {CW{1'b0}}) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          runs_left <= head;
          if (head == {RUN_W{1'b0}}) begin
            state <= S_IDLE;
          end else begin
            state <= S_FIRE;
            start <= ready;
          end
        end
        S_FIRE: begin
          if (start) begin
            state <= S_WAIT_ACK;
            timer <= TW'(1);
          end else if (ready) begin
            start <= 1'b1;
          end
        end
        S_WAIT_ACK: begin
          if (!ready) begin
            state <= S_WAIT_DONE;
          end else if (timer >= TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_ERROR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (ready) begin
            if (runs_left <= RUN_W'(1)) begin
              runs_left  <= {RUN_W{1'b0}};
              batch_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              runs_left <= runs_left - RUN_W'(1);
              start     <= 1'b1;
              state     <= S_FIRE;
            end
          end
        end
        S_ERROR: begin
          state <= S_ERROR;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef COUNTDOWN_SCHED_STATS_EN
  // Saturating tally of counter runs that reported completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_runs <= 32'd0;
    end else if ((state == S_WAIT_DONE) && ready && (stat_runs != 32'hFFFF_FFFF)) begin
      stat_runs <= stat_runs + 32'd1;
    end else begin
      stat_runs <= stat_runs;
    end
  end
`endif

endmodule

// File: tb/tb_countdown_scheduler.sv
// Scoreboard bench for countdown_scheduler: directed requests against a small counter model.
module tb_countdown_scheduler;
  localparam int RUN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [RUN_W-1:0] req_runs;
  logic             start;
  logic             ready;
  logic             busy;
  logic [RUN_W-1:0] runs_left;
  logic             batch_done;
  logic             timeout_err;
`ifdef COUNTDOWN_SCHED_STATS_EN
  logic [31:0]      stat_runs;
`endif

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0: normal counter, 1: hold ready low, 2: never drop ready
  int dly    = 0;
  int batch_starts = 0;
  logic prev_start = 1'b0;
  int exp_start_q[$];   // expected runs_left at each start pulse
  int exp_done_q[$];    // expected number of starts in each completed batch

  always #5 clk = ~clk;

  countdown_scheduler #(.DEPTH(4), .RUN_W(RUN_W), .ACK_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_runs    (req_runs),
    .start       (start),
    .ready       (ready),
    .busy        (busy),
    .runs_left   (runs_left),
    .batch_done  (batch_done),
`ifdef COUNTDOWN_SCHED_STATS_EN
    .stat_runs   (stat_runs),
`endif
    .timeout_err (timeout_err)
  );

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endfunction

  // Counter model: ready drops after a start and returns five cycles later.
  initial begin
    ready = 1'b1;
    forever begin
      @(negedge clk);
      if (mode == 1) begin
        ready = 1'b0;
        dly   = 0;
      end else if (mode == 2) begin
        ready = 1'b1;
      end else if (start) begin
        ready = 1'b0;
        dly   = 5;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) ready = 1'b1;
      end else begin
        ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents start or batch_done.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        batch_starts = 0;
        prev_start   = 1'b0;
      end else begin
        if (start) begin
          check("start_one_cycle", prev_start, 0);
          check("start_expected", exp_start_q.size() > 0, 1);
          if (exp_start_q.size() > 0) check("start_runs_left", runs_left, exp_start_q.pop_front());
          batch_starts++;
        end
        if (batch_done) begin
          check("done_expected", exp_done_q.size() > 0, 1);
          check("done_runs_left_zero", runs_left, 0);
          if (exp_done_q.size() > 0) check("done_batch_starts", batch_starts, exp_done_q.pop_front());
          batch_starts = 0;
        end
        prev_start = start;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input int r);
    @(negedge clk);
    req_valid = 1'b1;
    req_runs  = RUN_W'(r);
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
    check("push_accepted", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic wait_start(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (start) break;
    end
    check("start_seen", start, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_runs = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset
    repeat (8) begin
      @(negedge clk);
      check("t1_start", start, 0);
      check("t1_busy", busy, 0);
      check("t1_req_ready", req_ready, 1);
      check("t1_runs_left", runs_left, 0);
      check("t1_timeout_err", timeout_err, 0);
    end

    // 2: single batch of 3 runs, first start three cycles after acceptance
    exp_start_q.push_back(3); exp_start_q.push_back(2); exp_start_q.push_back(1);
    exp_done_q.push_back(3);
    push(3);
    check("t2_no_early_start_a", start, 0);
    @(negedge clk);
    check("t2_no_early_start_b", start, 0);
    @(negedge clk);
    check("t2_start_latency", start, 1);
    wait_idle(200);
    check("t2_sb_empty", exp_start_q.size() + exp_done_q.size(), 0);

    // 3: back-pressure with counter stuck busy
    mode = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      exp_start_q.push_back(1);
      exp_done_q.push_back(1);
    end
    for (int i = 0; i < 5; i++) push(1);
    check("t3_full_req_ready", req_ready, 0);
    check("t3_full_busy", busy, 1);
    req_valid = 1'b1;
    req_runs  = 8'd1;
    repeat (4) begin
      @(negedge clk);
      check("t3_held_off", req_ready, 0);
    end
    mode = 0;
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
    check("t3_extra_accepted", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle(600);
    check("t3_sb_empty", exp_start_q.size() + exp_done_q.size(), 0);

    // 4: zero-run request is dropped silently
    exp_start_q.push_back(2); exp_start_q.push_back(1);
    exp_done_q.push_back(2);
    push(0);
    push(2);
    wait_idle(200);
    check("t4_sb_empty", exp_start_q.size() + exp_done_q.size(), 0);
`ifdef COUNTDOWN_SCHED_STATS_EN
    check("t4_stat_runs", stat_runs, 11);
`endif

    // 5: counter never acknowledges
    mode = 2;
    exp_start_q.push_back(1);
    push(1);
    wait_start(50);
    repeat (15) @(negedge clk);
    check("t5_err_before_16", timeout_err, 0);
    @(negedge clk);
    check("t5_err_at_16", timeout_err, 1);
    repeat (10) @(negedge clk);
    check("t5_err_sticky", timeout_err, 1);
    check("t5_req_ready", req_ready, 0);
    check("t5_busy", busy, 1);
    do_reset();
    mode = 0;
    check("t5_rst_err", timeout_err, 0);
    check("t5_rst_req_ready", req_ready, 1);
    check("t5_rst_busy", busy, 0);

    // 6: reset while waiting for the counter with two requests queued
    mode = 1;
    repeat (3) @(negedge clk);
    exp_start_q.push_back(3);
    push(3);
    push(2);
    push(1);
    mode = 0;
    wait_start(50);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_start", start, 0);
    check("t6_busy", busy, 0);
    check("t6_runs_left", runs_left, 0);
    check("t6_req_ready", req_ready, 1);
    check("t6_batch_done", batch_done, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_still_idle", busy, 0);
    check("t6_sb_empty", exp_start_q.size() + exp_done_q.size(), 0);
`ifdef COUNTDOWN_SCHED_STATS_EN
    check("t6_stat_runs", stat_runs, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
